frame_checker: RTL and testbench
================================

# frame_checker

Receive-side counterpart of the frame generator. Accepts a byte stream of fixed-length frames plus the generator's CRC-8, recomputes the CRC and stores the payload in a frame buffer. Reports pass/fail, then forwards the checked payload downstream over a ready/valid handshake. Sits between the link/deserialiser side and the frame consumer.

## Interface
- FRAME_LEN, 16: payload bytes per frame (2..256).
- CRC_POLY, 8'h07: CRC-8 polynomial, x^8+x^2+x+1.
- CRC_INIT, 8'h00: CRC seed at frame start.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- frame_data  in  8  received payload byte.
- in_valid  in  1  frame_data valid this cycle.
- in_first  in  1  marks byte 0 of a frame; qualified by in_valid.
- crc  in  8  received CRC; sampled with the last payload byte.
- in_ready  out  1  block accepts a byte this cycle.
- out_data  out  8  buffered payload byte.
- out_index  out  $clog2(FRAME_LEN)  position of out_data in the frame.
- out_valid  out  1  out_data valid.
- out_err  out  1  frame being drained failed CRC.
- out_ready  in  1  downstream accepts out_data.
- frame_done  out  1  one-cycle pulse: frame checked.
- crc_ok  out  1  one-cycle pulse with frame_done: CRC matched.
- crc_calc  out  8  computed CRC, held until next frame_done.
- framing_err  out  1  one-cycle pulse: framing violation.
- overrun  out  1  sticky; in_valid seen while in_ready low. Cleared only by reset.

## Operation
- States: IDLE, RECV, CHECK, DRAIN.
- A byte is accepted when in_valid && in_ready. in_ready = 1 in IDLE/RECV, 0 in CHECK/DRAIN.
- IDLE: an accepted byte with in_first stores buffer[0], loads crc_acc = crc8(CRC_INIT, byte), sets count=1 and moves to RECV. An accepted byte without in_first is dropped and pulses framing_err.
- RECV: an accepted byte is stored at buffer[count], crc_acc updated, count incremented.
- When the accepted byte is the last one (count==FRAME_LEN-1), crc is latched and the block moves to CHECK.
- in_first during RECV: the partial frame is discarded and framing_err pulses. The byte is taken as byte 0 of a new frame.
- CRC arithmetic: MSB-first, non-reflected, no final XOR, 8-bit bitwise update per byte.
- CHECK: lasts one cycle. Pulses frame_done, drives crc_ok = (crc_acc == latched crc), loads crc_calc, then moves to DRAIN.
- DRAIN: presents buffer[out_index] with out_valid=1, starting at out_index 0.
  - out_data and out_index are held stable until out_ready.
  - Each handshake advances out_index.
  - The handshake at FRAME_LEN-1 returns to IDLE.
- Reset asserted in any state returns to IDLE immediately. Buffer contents are not cleared and are never exposed.
- Reset values: in_ready 1 (asynchronous combinational from IDLE). All other outputs 0: out_data, out_index, out_valid, out_err, frame_done, crc_ok, crc_calc, framing_err, overrun.

## Timing
- Last byte accepted at cycle N -> frame_done/crc_ok at N+1 -> first out_valid at N+2.
- Drain takes at least FRAME_LEN cycles; back-to-back with out_ready held high.
- in_ready rises the cycle after the final drain handshake.
- Minimum frame period: 2*FRAME_LEN+1 cycles.

## Configuration
- FRAME_CHECKER_DROP_BAD_EN defined: a failing frame goes CHECK -> IDLE. No out_valid is produced and out_err stays 0.
- FRAME_CHECKER_DROP_BAD_EN undefined: every frame is drained. out_err is held at !crc_ok for the whole drain.

## Structure
- frame_pkg: state enum, default FRAME_LEN/CRC_POLY/CRC_INIT, and the crc8_next(crc, byte, poly) function.
- One sub-module: crc8_update, a combinational byte-wide CRC step. It is instantiated once and feeds crc_acc.
- Buffer: a register array of FRAME_LEN x 8, written by count and read by out_index.

## Test plan
- 16 bytes 0x00 with in_first on byte 0, crc=0x00 -> frame_done, crc_ok=1, crc_calc=0x00. Then 16 beats out_data=0x00 with out_index 0..15.
- 15 bytes 0x00 followed by 0x01, crc=0x07 -> crc_ok=1, crc_calc=0x07. Beat 15 has out_data=0x01.
- Same payload, crc=0x06 -> crc_ok=0, crc_calc=0x07. With the macro: no out_valid, in_ready high at N+2. Without: 16 beats with out_err=1.
- in_first re-asserted on byte 7 -> framing_err pulse. The following 16 bytes (crc=0x00, all zero) check OK from the new start.
- out_ready low for 5 cycles at out_index 3, with in_valid high during drain -> out_data/out_index held at 3, in_ready=0, overrun=1 (sticky).
- reset asserted at out_index 9 -> next cycle out_valid=0, in_ready=1. A fresh frame then checks and drains normally.

Source files
------------

// File: rtl/frame_pkg.sv
// frame_pkg: shared types, default parameters and the CRC-8 step function
// for the frame checker.
//   state_t            : checker FSM states (IDLE, RECV, CHECK, DRAIN)
//   FRAME_LEN_DEFAULT  : payload bytes per frame
//   CRC_POLY_DEFAULT   : CRC-8 polynomial x^8+x^2+x+1
//   CRC_INIT_DEFAULT   : CRC seed at frame start
//   crc8_next()        : one byte of MSB-first, non-reflected CRC-8
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int         FRAME_LEN_DEFAULT = 16;
  localparam logic [7:0] CRC_POLY_DEFAULT  = 8'h07;
  localparam logic [7:0] CRC_INIT_DEFAULT  = 8'h00;

  // Shift the byte in MSB first; feedback is the outgoing CRC MSB xor data bit.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0};
      if (fb) begin
        c = c ^ poly;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_checker_crc8_update.sv
// crc8_update: combinational byte-wide CRC-8 step.
//   POLY     : CRC polynomial
//   crc_in   : running CRC before this byte
//   data_in  : byte to absorb
//   crc_out  : running CRC after this byte
module crc8_update
  import frame_pkg::*;
#(
  parameter logic [7:0] POLY = CRC_POLY_DEFAULT
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  // Single byte CRC step.
  always_comb begin
    crc_out = crc8_next(crc_in, data_in, POLY);
  end

endmodule

// File: rtl/frame_checker.sv
// frame_checker: receives fixed-length frames plus a CRC-8, recomputes the
// CRC while buffering the payload, reports the result, then drains the
// buffered payload downstream over ready/valid.
// Optional build macro: FRAME_CHECKER_DROP_BAD_EN -- frames failing CRC are
// discarded instead of drained.
// Ports:
//   clk, reset (async, active-low)
//   frame_data/in_valid/in_first/crc -> in_ready : receive side
//   out_data/out_index/out_valid/out_err <- out_ready : drain side
//   frame_done, crc_ok, crc_calc : check result
//   framing_err (pulse), overrun (sticky until reset) : error status
module frame_checker
  import frame_pkg::*;
#(
  parameter int         FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter logic [7:0] CRC_POLY  = CRC_POLY_DEFAULT,
  parameter logic [7:0] CRC_INIT  = CRC_INIT_DEFAULT,
  localparam int        IW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    frame_data,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic [7:0]    crc,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic [IW-1:0] out_index,
  output logic          out_valid,
  output logic          out_err,
  input  logic          out_ready,
  output logic          frame_done,
  output logic          crc_ok,
  output logic [7:0]    crc_calc,
  output logic          framing_err,
  output logic          overrun
);

  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);
  localparam logic [IW-1:0] IDX_ZERO = '0;

  state_t          state_q, state_d;
  logic [IW-1:0]   count_q, count_d;
  logic [7:0]      crc_acc_q, crc_acc_d;
  logic [7:0]      buffer_q [FRAME_LEN];
  logic [7:0]      out_data_q, out_data_d;
  logic [IW-1:0]   out_index_q, out_index_d;
  logic            out_valid_q, out_valid_d;
  logic            out_err_q, out_err_d;
  logic            frame_done_q, frame_done_d;
  logic            crc_ok_q, crc_ok_d;
  logic [7:0]      crc_calc_q, crc_calc_d;
  logic            framing_err_q, framing_err_d;
  logic            overrun_q, overrun_d;

  logic            in_ready_s, accept_s, restart_s, wr_en_s, last_s;
  logic [IW-1:0]   wr_idx_s;
  logic [7:0]      crc_seed_s, crc_step_s;

  // Receive side is open only while collecting a frame.
  always_comb begin
    in_ready_s = (state_q == ST_IDLE) || (state_q == ST_RECV);
    accept_s   = in_valid && in_ready_s;
    restart_s  = accept_s && in_first;
    wr_en_s    = restart_s || (accept_s && (state_q == ST_RECV));
    wr_idx_s   = restart_s ? IDX_ZERO : count_q;
    last_s     = accept_s && !in_first && (state_q == ST_RECV) && (count_q == LAST_IDX);
    crc_seed_s = restart_s ? CRC_INIT : crc_acc_q;
  end

  crc8_update #(.POLY(CRC_POLY)) u_crc8_update (
    .crc_in  (crc_seed_s),
    .data_in (frame_data),
    .crc_out (crc_step_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (restart_s) state_d = ST_RECV;
        else           state_d = ST_IDLE;
      end
      ST_RECV: begin
        if (last_s) state_d = ST_CHECK;
        else        state_d = ST_RECV;
      end
      ST_CHECK: begin
`ifdef FRAME_CHECKER_DROP_BAD_EN
        if (crc_ok_q) state_d = ST_DRAIN;
        else          state_d = ST_IDLE;
`else
        state_d = ST_DRAIN;
`endif
      end
      ST_DRAIN: begin
        if (out_ready && (out_index_q == LAST_IDX)) state_d = ST_IDLE;
        else                                        state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    count_d       = wr_en_s ? (restart_s ? IDX_ONE : count_q + IDX_ONE) : count_q;
    crc_acc_d     = wr_en_s ? crc_step_s : crc_acc_q;
    // Orphan byte in IDLE, or a new frame start cutting a partial frame short.
    framing_err_d = accept_s && (((state_q == ST_IDLE) && !in_first) ||
                                 ((state_q == ST_RECV) && in_first));
    // Result is registered on the last-byte edge so it is visible in CHECK.
    frame_done_d  = last_s;
    crc_ok_d      = last_s && (crc_step_s == crc);
    crc_calc_d    = last_s ? crc_step_s : crc_calc_q;
    overrun_d     = overrun_q || (in_valid && !in_ready_s);

    if (state_d == ST_DRAIN) begin
      if (state_q != ST_DRAIN) begin
        out_index_d = IDX_ZERO;
      end else if (out_ready) begin
        out_index_d = out_index_q + IDX_ONE;
      end else begin
        out_index_d = out_index_q;
      end
      out_data_d  = buffer_q[out_index_d];
      out_valid_d = 1'b1;
      out_err_d   = (state_q == ST_CHECK) ? !crc_ok_q : out_err_q;
    end else begin
      out_index_d = IDX_ZERO;
      out_data_d  = 8'h00;
      out_valid_d = 1'b0;
      out_err_d   = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q       <= IDX_ZERO;
      crc_acc_q     <= 8'h00;
      out_data_q    <= 8'h00;
      out_index_q   <= IDX_ZERO;
      out_valid_q   <= 1'b0;
      out_err_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      crc_ok_q      <= 1'b0;
      crc_calc_q    <= 8'h00;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      count_q       <= count_d;
      crc_acc_q     <= crc_acc_d;
      out_data_q    <= out_data_d;
      out_index_q   <= out_index_d;
      out_valid_q   <= out_valid_d;
      out_err_q     <= out_err_d;
      frame_done_q  <= frame_done_d;
      crc_ok_q      <= crc_ok_d;
      crc_calc_q    <= crc_calc_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  // Payload buffer; contents are never cleared, only exposed during drain.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buffer_q[wr_idx_s] <= frame_data;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;
  assign out_valid   = out_valid_q;
  assign out_err     = out_err_q;
  assign frame_done  = frame_done_q;
  assign crc_ok      = crc_ok_q;
  assign crc_calc    = crc_calc_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_checker.sv
// tb_frame_checker: directed bench for frame_checker (FRAME_LEN = 16).
module tb_frame_checker;

  logic       clk;
  logic       reset;
  logic [7:0] frame_data;
  logic       in_valid;
  logic       in_first;
  logic [7:0] crc;
  logic       in_ready;
  logic [7:0] out_data;
  logic [3:0] out_index;
  logic       out_valid;
  logic       out_err;
  logic       out_ready;
  logic       frame_done;
  logic       crc_ok;
  logic [7:0] crc_calc;
  logic       framing_err;
  logic       overrun;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] pay [16];
  logic [7:0] exp_crc;

  frame_checker dut (
    .clk         (clk),
    .reset       (reset),
    .frame_data  (frame_data),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .crc         (crc),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_err     (out_err),
    .out_ready   (out_ready),
    .frame_done  (frame_done),
    .crc_ok      (crc_ok),
    .crc_calc    (crc_calc),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-8 (poly 0x07, seed 0x00) over pay[], bit-serial.
  function automatic logic [7:0] ref_crc();
    logic [7:0] c;
    logic       top;
    c = 8'h00;
    for (int i = 0; i < 16; i++) begin
      for (int b = 7; b >= 0; b--) begin
        top = c[7] ^ pay[i][b];
        c   = {c[6:0], 1'b0} ^ (top ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic f, input logic [7:0] c);
    @(negedge clk);
    frame_data = d;
    in_first   = f;
    crc        = c;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c);
    for (int i = 0; i < 16; i++) send_byte(pay[i], (i == 0), c);
  endtask

  task automatic check_result(input logic ok, input logic [7:0] calc);
    @(negedge clk);
    chk("frame_done", frame_done, 1);
    chk("crc_ok", crc_ok, ok);
    chk("crc_calc", crc_calc, calc);
    chk("in_ready_check", in_ready, 0);
    chk("out_valid_check", out_valid, 0);
  endtask

  // Drain with out_ready high; optional 5-cycle stall at stall_at, optional
  // reset at stop_at (values >= 16 disable those).
  task automatic drain(input logic e, input int stall_at, input int stop_at);
    bit stopped = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("out_valid", out_valid, 1);
      chk("out_index", out_index, i);
      chk("out_data", out_data, pay[i]);
      chk("out_err", out_err, e);
      if (i == stop_at) begin
        reset   = 1'b0;
        stopped = 1'b1;
        break;
      end
      if (i == stall_at) begin
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        frame_data = 8'hAA;
        repeat (5) begin
          @(negedge clk);
          chk("stall_index", out_index, i);
          chk("stall_data", out_data, pay[i]);
          chk("stall_valid", out_valid, 1);
          chk("stall_in_ready", in_ready, 0);
          chk("overrun_set", overrun, 1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
    end
    @(negedge clk);
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    if (stopped) begin
      chk("reset_overrun", overrun, 0);
      chk("reset_out_index", out_index, 0);
      reset = 1'b1;
    end
  endtask

  initial begin
    reset      = 1'b0;
    frame_data = 8'h00;
    in_valid   = 1'b0;
    in_first   = 1'b0;
    crc        = 8'h00;
    out_ready  = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_crc_calc", crc_calc, 0);
    chk("rst_framing_err", framing_err, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b1;

    // Orphan byte in IDLE: dropped with a framing error pulse.
    send_byte(8'h33, 1'b0, 8'h00);
    @(negedge clk);
    chk("idle_framing_err", framing_err, 1);
    chk("idle_in_ready", in_ready, 1);
    @(negedge clk);
    chk("idle_framing_clr", framing_err, 0);
    chk("idle_no_done", frame_done, 0);

    // All-zero frame, CRC 0x00.
    for (int i = 0; i < 16; i++) pay[i] = 8'h00;
    send_frame(8'h00);
    check_result(1'b1, 8'h00);
    drain(1'b0, 99, 99);

    // Last byte 0x01 -> CRC 0x07.
    pay[15] = 8'h01;
    send_frame(8'h07);
    check_result(1'b1, 8'h07);
    drain(1'b0, 99, 99);

    // Same payload, wrong received CRC.
    send_frame(8'h06);
    check_result(1'b0, 8'h07);
`ifdef FRAME_CHECKER_DROP_BAD_EN
    @(negedge clk);
    chk("drop_out_valid", out_valid, 0);
    chk("drop_in_ready", in_ready, 1);
    chk("drop_out_err", out_err, 0);
`else
    drain(1'b1, 99, 99);
`endif

    // in_first re-asserted on byte 7 restarts the frame.
    pay[15] = 8'h00;
    for (int i = 0; i < 7; i++) send_byte(8'h00, (i == 0), 8'h00);
    send_byte(8'h00, 1'b1, 8'h00);
    @(negedge clk);
    chk("restart_framing_err", framing_err, 1);
    chk("restart_in_ready", in_ready, 1);
    for (int i = 1; i < 16; i++) send_byte(8'h00, 1'b0, 8'h00);
    check_result(1'b1, 8'h00);
    drain(1'b0, 99, 99);

    // Ramp payload, stall at index 3 with in_valid held high.
    for (int i = 0; i < 16; i++) pay[i] = 8'(i);
    exp_crc = ref_crc();
    send_frame(exp_crc);
    check_result(1'b1, exp_crc);
    drain(1'b0, 3, 99);
    chk("overrun_sticky", overrun, 1);

    // Reset in the middle of a drain, then a fresh frame.
    for (int i = 0; i < 16; i++) pay[i] = 8'hF0 ^ 8'(i);
    exp_crc = ref_crc();
    send_frame(exp_crc);
    check_result(1'b1, exp_crc);
    drain(1'b0, 99, 9);
    for (int i = 0; i < 16; i++) pay[i] = 8'h5A + 8'(3 * i);
    exp_crc = ref_crc();
    send_frame(exp_crc);
    check_result(1'b1, exp_crc);
    drain(1'b0, 99, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
